// File: rtl/vfp_issue_sequencer_if.sv
// Purpose: bundles the core-side and FP-unit-side signals of vfp_issue_sequencer.
// Latency: n/a (wiring only).
// Backpressure: fpu_req/fpu_gnt handshake toward the FP unit, stall toward the core.
// Ports: core side  start/op/half/srca/srcb in, stall/done/result/err out;
//        FPU side   fpu_req/fpu_op/fpu_half/fpu_a/fpu_b out, fpu_gnt/fpu_done/fpu_y in.
interface vfp_issue_sequencer_if;
    logic        start;
    logic        op;
    logic        half;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic        err;
    logic        fpu_req;
    logic        fpu_gnt;
    logic        fpu_op;
    logic        fpu_half;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        fpu_done;
    logic [31:0] fpu_y;

    // Sequencer side.
    modport slave (
        input  start, op, half, srca, srcb, fpu_gnt, fpu_done, fpu_y,
        output stall, done, result, err, fpu_req, fpu_op, fpu_half, fpu_a, fpu_b
    );

    // Environment side (core plus FP unit).
    modport master (
        output start, op, half, srca, srcb, fpu_gnt, fpu_done, fpu_y,
        input  stall, done, result, err, fpu_req, fpu_op, fpu_half, fpu_a, fpu_b
    );
endinterface

// File: rtl/vfp_issue_sequencer.sv
// Purpose: runs one vector FP op (fp32, or two fp16 lanes) through a shared variable-latency FP unit.
// Latency: ideal FPU gives done 3 cycles after start (fp32), 5 cycles (fp16); abort after TIMEOUT stuck cycles.
// Backpressure: core stalled from the start cycle until DONE; FPU request held until fpu_gnt.
// Ports: i_clk, i_reset (sync, active-high), io_vfp (slave modport of vfp_issue_sequencer_if).
module vfp_issue_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    vfp_issue_sequencer_if.slave  io_vfp
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam int              CW          = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_LAST    = CW'(TIMEOUT - 1);
    localparam logic [31:0]     QNAN_FP32   = 32'h7FC0_0000;
    localparam logic [31:0]     QNAN_FP16X2 = 32'h7E00_7E00;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_lane;
    logic          r_op;
    logic          r_half;
    logic [31:0]   r_srca;
    logic [31:0]   r_srcb;
    logic [31:0]   r_result;
    logic          r_err;
    logic          r_done;
    logic          r_fpu_req;
    logic          r_fpu_op;
    logic          r_fpu_half;
    logic [31:0]   r_fpu_a;
    logic [31:0]   r_fpu_b;

    logic          w_abort;

    // Stuck in ISSUE or WAIT: the exit event did not arrive in the last allowed cycle.
    assign w_abort = (r_cnt == CNT_LAST) &&
                     (((r_state == S_ISSUE) && !io_vfp.fpu_gnt) ||
                      ((r_state == S_WAIT)  && !io_vfp.fpu_done));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lane     <= 1'b0;
            r_op       <= 1'b0;
            r_half     <= 1'b0;
            r_srca     <= '0;
            r_srcb     <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
            r_fpu_req  <= 1'b0;
            r_fpu_op   <= 1'b0;
            r_fpu_half <= 1'b0;
            r_fpu_a    <= '0;
            r_fpu_b    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state    <= S_DONE;
                r_cnt      <= '0;
                r_done     <= 1'b1;
                r_err      <= 1'b1;
                r_result   <= r_half ? QNAN_FP16X2 : QNAN_FP32;
                r_fpu_req  <= 1'b0;
                r_fpu_op   <= 1'b0;
                r_fpu_half <= 1'b0;
                r_fpu_a    <= '0;
                r_fpu_b    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (io_vfp.start) begin
                            r_state    <= S_ISSUE;
                            r_cnt      <= '0;
                            r_lane     <= 1'b0;
                            r_op       <= io_vfp.op;
                            r_half     <= io_vfp.half;
                            r_srca     <= io_vfp.srca;
                            r_srcb     <= io_vfp.srcb;
                            // Lane 0 payload is loaded straight from the core operands.
                            r_fpu_req  <= 1'b1;
                            r_fpu_op   <= io_vfp.op;
                            r_fpu_half <= io_vfp.half;
                            r_fpu_a    <= io_vfp.half ? {16'h0, io_vfp.srca[15:0]} : io_vfp.srca;
                            r_fpu_b    <= io_vfp.half ? {16'h0, io_vfp.srcb[15:0]} : io_vfp.srcb;
                        end
                    end
                    S_ISSUE: begin
                        if (io_vfp.fpu_gnt) begin
                            r_state    <= S_WAIT;
                            r_cnt      <= '0;
                            r_fpu_req  <= 1'b0;
                            r_fpu_op   <= 1'b0;
                            r_fpu_half <= 1'b0;
                            r_fpu_a    <= '0;
                            r_fpu_b    <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (io_vfp.fpu_done) begin
                            r_cnt <= '0;
                            if (!r_half)
                                r_result <= io_vfp.fpu_y;
                            else if (!r_lane)
                                r_result[15:0] <= io_vfp.fpu_y[15:0];
                            else
                                r_result[31:16] <= io_vfp.fpu_y[15:0];
                            if (r_half && !r_lane) begin
                                // Second fp16 lane: upper halves of the latched operands.
                                r_state    <= S_ISSUE;
                                r_lane     <= 1'b1;
                                r_fpu_req  <= 1'b1;
                                r_fpu_op   <= r_op;
                                r_fpu_half <= 1'b1;
                                r_fpu_a    <= {16'h0, r_srca[31:16]};
                                r_fpu_b    <= {16'h0, r_srcb[31:16]};
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_err   <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Combinational so the core already holds in the cycle it presents start.
    assign io_vfp.stall    = ((r_state == S_IDLE) && io_vfp.start) ||
                             (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign io_vfp.done     = r_done;
    assign io_vfp.result   = r_result;
    assign io_vfp.err      = r_err;
    assign io_vfp.fpu_req  = r_fpu_req;
    assign io_vfp.fpu_op   = r_fpu_op;
    assign io_vfp.fpu_half = r_fpu_half;
    assign io_vfp.fpu_a    = r_fpu_a;
    assign io_vfp.fpu_b    = r_fpu_b;
endmodule

// File: tb/tb_vfp_issue_sequencer.sv
// Purpose: self-checking bench for vfp_issue_sequencer with a behavioural FP-unit responder.
// Latency: n/a (testbench).
// Backpressure: responder grants after a programmable delay and returns results after another.
module tb_vfp_issue_sequencer;
    localparam int T = 16;

    typedef struct packed {
        logic        op;
        logic        half;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    vfp_issue_sequencer_if vif ();

    vfp_issue_sequencer #(.TIMEOUT(T)) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .io_vfp (vif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in arithmetic for the FP unit; only needs to be deterministic.
    function automatic logic [31:0] fake32(input logic op, input logic [31:0] a, input logic [31:0] b);
        return op ? (a * b + 32'h1234) : (a + b);
    endfunction

    // Expected packed result of a completed op, computed lane by lane.
    function automatic logic [31:0] exp_result(input logic op, input logic half,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [31:0] lo, hi;
        if (!half) return fake32(op, a, b);
        lo = fake32(op, {16'h0, a[15:0]},  {16'h0, b[15:0]});
        hi = fake32(op, {16'h0, a[31:16]}, {16'h0, b[31:16]});
        return {hi[15:0], lo[15:0]};
    endfunction

    // ---------------- FP unit responder ----------------
    int          g_dly = 0;      // cycles of req before gnt
    int          d_dly = 1;      // cycles from accept to fpu_done
    bit          hang  = 0;      // never return fpu_done
    bit          inj   = 0;      // stray fpu_done injection
    logic [31:0] inj_y = '0;
    int          age   = 0;
    int          pend  = 0;
    logic [31:0] pend_y;
    logic [31:0] rf;
    logic [31:0] resp_q[$];
    req_t        req_log[$];
    req_t        cur, first_seen;
    int          unstable = 0;
    int          idle_nz  = 0;

    initial begin
        vif.fpu_gnt  = 1'b0;
        vif.fpu_done = 1'b0;
        vif.fpu_y    = '0;
        forever begin
            @(negedge clk);
            vif.fpu_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0 && !hang) begin
                    vif.fpu_done = 1'b1;
                    vif.fpu_y    = pend_y;
                end
            end
            if (inj) begin
                vif.fpu_done = 1'b1;
                vif.fpu_y    = inj_y;
            end
            if (!vif.fpu_req) begin
                age         = 0;
                vif.fpu_gnt = 1'b0;
                if (vif.fpu_op || vif.fpu_half || vif.fpu_a != 0 || vif.fpu_b != 0) idle_nz++;
            end else begin
                cur.op   = vif.fpu_op;
                cur.half = vif.fpu_half;
                cur.a    = vif.fpu_a;
                cur.b    = vif.fpu_b;
                if (age == 0) first_seen = cur;
                else if (cur != first_seen) unstable++;
                if (age == g_dly) begin
                    vif.fpu_gnt = 1'b1;
                    req_log.push_back(cur);
                    pend = d_dly;
                    if (resp_q.size() > 0) begin
                        pend_y = resp_q.pop_front();
                    end else begin
                        rf = fake32(cur.op, cur.a, cur.b);
                        pend_y = cur.half ? {cur.a[15:0] ^ 16'hA5A5, rf[15:0]} : rf;
                    end
                end else begin
                    vif.fpu_gnt = 1'b0;
                end
                age++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one instruction and records what the core would see (no checking here).
    task automatic do_op(input logic op, input logic half, input logic [31:0] a, input logic [31:0] b,
                         input int extra_start, output int done_at, output int n_done,
                         output int stall_cnt, output logic [31:0] res, output logic e,
                         output logic req_at_done);
        int last;
        done_at = -1; n_done = 0; stall_cnt = 0; res = '0; e = 1'b0; req_at_done = 1'b0; last = 60;
        req_log.delete();
        unstable = 0;
        @(posedge clk); #1;
        vif.start = 1'b1; vif.op = op; vif.half = half; vif.srca = a; vif.srcb = b;
        for (int rel = 0; rel <= last; rel++) begin
            @(negedge clk);
            if (vif.stall) stall_cnt++;
            if (vif.done) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = rel; res = vif.result; e = vif.err; req_at_done = vif.fpu_req;
                    last = rel + 2;
                end
            end
            @(posedge clk); #1;
            vif.start = (rel + 1 == extra_start);
            vif.op    = 1'($urandom);
            vif.half  = 1'($urandom);
            vif.srca  = $urandom;
            vif.srcb  = $urandom;
        end
        vif.start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [101:0] outs;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        outs = {vif.stall, vif.done, vif.err, vif.fpu_req, vif.fpu_op, vif.fpu_half,
                vif.result, vif.fpu_a, vif.fpu_b};
        total++; if (outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
    endtask

    task automatic test_fp32_add;
        int da, nd, sc; logic [31:0] r; logic e, rq;
        g_dly = 0; d_dly = 1;
        resp_q.push_back(32'h4040_0000);
        do_op(1'b0, 1'b0, 32'h3F80_0000, 32'h4000_0000, -1, da, nd, sc, r, e, rq);
        total++; if (da !== 3) begin bad++; $display("FAIL fp32_done_cycle got=%0d want=3", da); end
        total++; if (sc !== 3) begin bad++; $display("FAIL fp32_stall_cycles got=%0d want=3", sc); end
        total++; if (r !== 32'h4040_0000) begin bad++; $display("FAIL fp32_result got=%h want=40400000", r); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL fp32_err got=%b want=0", e); end
        total++; if (nd !== 1) begin bad++; $display("FAIL fp32_done_count got=%0d want=1", nd); end
        total++;
        if (req_log.size() != 1 || req_log[0] !== req_t'{1'b0, 1'b0, 32'h3F80_0000, 32'h4000_0000}) begin
            bad++; $display("FAIL fp32_request got_n=%0d want one {0,0,3F800000,40000000}", req_log.size());
        end
    endtask

    task automatic test_fp16_mul;
        int da, nd, sc; logic [31:0] r; logic e, rq;
        g_dly = 0; d_dly = 1;
        resp_q.push_back(32'hBEEF_4000);
        resp_q.push_back(32'h1234_4600);
        do_op(1'b1, 1'b1, 32'h4000_3C00, 32'h4200_4000, -1, da, nd, sc, r, e, rq);
        total++; if (da !== 5) begin bad++; $display("FAIL fp16_done_cycle got=%0d want=5", da); end
        total++; if (r !== 32'h4600_4000) begin bad++; $display("FAIL fp16_result got=%h want=46004000", r); end
        total++;
        if (req_log.size() != 2) begin
            bad++; $display("FAIL fp16_request_count got=%0d want=2", req_log.size());
        end else if (req_log[0] !== req_t'{1'b1, 1'b1, 32'h0000_3C00, 32'h0000_4000} ||
                     req_log[1] !== req_t'{1'b1, 1'b1, 32'h0000_4000, 32'h0000_4200}) begin
            bad++; $display("FAIL fp16_request_payload got=%h,%h", req_log[0], req_log[1]);
        end
    endtask

    task automatic test_slow_fpu;
        int da, nd, sc, want; logic [31:0] r, a, b; logic e, rq;
        g_dly = 3; d_dly = 4;
        for (int h = 0; h < 2; h++) begin
            a = $urandom; b = $urandom;
            want = 1 + (h + 1) * 8;
            do_op(1'b0, 1'(h), a, b, -1, da, nd, sc, r, e, rq);
            total++; if (da !== want) begin bad++; $display("FAIL slow_done_cycle half=%0d got=%0d want=%0d", h, da, want); end
            total++; if (r !== exp_result(1'b0, 1'(h), a, b)) begin bad++; $display("FAIL slow_result half=%0d got=%h want=%h", h, r, exp_result(1'b0, 1'(h), a, b)); end
            total++; if (e !== 1'b0 || nd !== 1) begin bad++; $display("FAIL slow_err_or_count half=%0d err=%b n=%0d want 0/1", h, e, nd); end
            total++; if (unstable !== 0) begin bad++; $display("FAIL slow_payload_stable half=%0d changes=%0d want=0", h, unstable); end
        end
        g_dly = 0; d_dly = 1;
    endtask

    task automatic test_timeout;
        int da, nd, sc; logic [31:0] r; logic e, rq;
        g_dly = 0; d_dly = 1; hang = 1;
        do_op(1'b1, 1'b1, $urandom, $urandom, -1, da, nd, sc, r, e, rq);
        hang = 0;
        // WAIT entered at cycle 2, abort done T cycles later.
        total++; if (da !== 2 + T) begin bad++; $display("FAIL wait_timeout_cycle got=%0d want=%0d", da, 2 + T); end
        total++; if (r !== 32'h7E00_7E00 || e !== 1'b1) begin bad++; $display("FAIL wait_timeout_result got=%h err=%b want=7e007e00 err=1", r, e); end
        total++; if (rq !== 1'b0 || nd !== 1) begin bad++; $display("FAIL wait_timeout_req req=%b n=%0d want 0/1", rq, nd); end
        g_dly = T + 4;
        do_op(1'b0, 1'b0, $urandom, $urandom, -1, da, nd, sc, r, e, rq);
        g_dly = 0;
        total++; if (da !== 1 + T) begin bad++; $display("FAIL issue_timeout_cycle got=%0d want=%0d", da, 1 + T); end
        total++; if (r !== 32'h7FC0_0000 || e !== 1'b1 || rq !== 1'b0) begin bad++; $display("FAIL issue_timeout_result got=%h err=%b req=%b want=7fc00000/1/0", r, e, rq); end
    endtask

    task automatic test_ignored_inputs;
        int da, nd, sc, n; logic [31:0] r, a, b; logic e, rq;
        g_dly = 0; d_dly = 6;
        a = $urandom; b = $urandom;
        do_op(1'b1, 1'b0, a, b, 3, da, nd, sc, r, e, rq);
        d_dly = 1;
        total++; if (da !== 8 || nd !== 1) begin bad++; $display("FAIL start_in_wait done_at=%0d n=%0d want 8/1", da, nd); end
        total++; if (r !== fake32(1'b1, a, b)) begin bad++; $display("FAIL start_in_wait_result got=%h want=%h", r, fake32(1'b1, a, b)); end
        @(posedge clk); #1; inj = 1; inj_y = ~r;
        @(posedge clk); #1; inj = 0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (vif.done) n++;
        end
        total++; if (n !== 0) begin bad++; $display("FAIL stray_done_pulses got=%0d want=0", n); end
        total++; if (vif.result !== r || vif.err !== 1'b0) begin bad++; $display("FAIL stray_done_hold got=%h err=%b want=%h err=0", vif.result, vif.err, r); end
    endtask

    task automatic test_back_to_back;
        int dq[$]; int mis; logic [31:0] a, b; logic exp_stall;
        g_dly = 0; d_dly = 1; mis = 0;
        a = $urandom; b = $urandom;
        @(posedge clk); #1;
        vif.start = 1'b1; vif.op = 1'b0; vif.half = 1'b0; vif.srca = a; vif.srcb = b;
        for (int rel = 0; rel < 15; rel++) begin
            @(negedge clk);
            if (vif.done) dq.push_back(rel);
            // Ops accepted at 0, 4, 8: busy for three cycles, then the DONE cycle.
            exp_stall = (rel <= 10) && (rel % 4 != 3);
            if (vif.stall !== exp_stall) mis++;
            @(posedge clk); #1;
            vif.start = (rel + 1 <= 8);
        end
        vif.start = 1'b0;
        total++; if (mis !== 0) begin bad++; $display("FAIL b2b_stall_pattern mismatches=%0d want=0", mis); end
        total++;
        if (dq.size() != 3 || dq[0] != 3 || dq[1] != 7 || dq[2] != 11) begin
            bad++; $display("FAIL b2b_done_cycles got_n=%0d want 3,7,11", dq.size());
        end
        total++; if (vif.result !== fake32(1'b0, a, b)) begin bad++; $display("FAIL b2b_result got=%h want=%h", vif.result, fake32(1'b0, a, b)); end
    endtask

    task automatic test_reset_mid_op;
        logic [101:0] outs; int n; int da, nd, sc; logic [31:0] r, a, b; logic e, rq;
        g_dly = 0; d_dly = 8;
        @(posedge clk); #1;
        vif.start = 1'b1; vif.op = 1'b1; vif.half = 1'b1; vif.srca = $urandom; vif.srcb = $urandom;
        @(posedge clk); #1; vif.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        outs = {vif.stall, vif.done, vif.err, vif.fpu_req, vif.fpu_op, vif.fpu_half,
                vif.result, vif.fpu_a, vif.fpu_b};
        total++; if (outs !== '0) begin bad++; $display("FAIL reset_mid_outputs got=%h want=0", outs); end
        // The abandoned lane-0 result lands a few cycles from now.
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (vif.done) n++;
        end
        total++; if (n !== 0 || vif.result !== 32'h0) begin bad++; $display("FAIL late_fpu_done n=%0d result=%h want 0/0", n, vif.result); end
        d_dly = 1;
        a = $urandom; b = $urandom;
        do_op(1'b0, 1'b0, a, b, -1, da, nd, sc, r, e, rq);
        total++; if (da !== 3 || r !== fake32(1'b0, a, b) || e !== 1'b0) begin
            bad++; $display("FAIL after_reset_op done_at=%0d result=%h err=%b want 3/%h/0", da, r, e, fake32(1'b0, a, b));
        end
    endtask

    task automatic test_random;
        int da, nd, sc, g, d, t, nacc; logic [31:0] r, a, b, er; logic e, rq, op, half, hg, eerr;
        req_t want;
        for (int i = 0; i < 30; i++) begin
            op = 1'($urandom); half = 1'($urandom); a = $urandom; b = $urandom;
            g = $urandom_range(0, 3); d = $urandom_range(1, 4); hg = 1'b0;
            case (i % 10)
                7: g = T - 1;
                8: d = T;
                9: if (half) hg = 1'b1; else g = T;
                default: ;
            endcase
            g_dly = g; d_dly = d; hang = hg;
            do_op(op, half, a, b, -1, da, nd, sc, r, e, rq);
            hang = 0;
            // Timeline model: ISSUE lasts g+1 cycles, WAIT lasts d; any stage longer than T aborts at T.
            t = 1; eerr = 1'b0; nacc = 0;
            for (int l = 0; l <= int'(half); l++) begin
                if (g >= T) begin t += T; eerr = 1'b1; break; end
                t += g + 1; nacc++;
                if (hg || d > T) begin t += T; eerr = 1'b1; break; end
                t += d;
            end
            er = eerr ? (half ? 32'h7E00_7E00 : 32'h7FC0_0000) : exp_result(op, half, a, b);
            total++; if (da !== t) begin bad++; $display("FAIL rnd%0d_done_cycle got=%0d want=%0d", i, da, t); end
            total++; if (r !== er || e !== eerr) begin bad++; $display("FAIL rnd%0d_result got=%h err=%b want=%h err=%b", i, r, e, er, eerr); end
            total++; if (nd !== 1 || sc !== t) begin bad++; $display("FAIL rnd%0d_done_stall n=%0d stall=%0d want 1/%0d", i, nd, sc, t); end
            total++;
            if (req_log.size() != nacc) begin
                bad++; $display("FAIL rnd%0d_req_count got=%0d want=%0d", i, req_log.size(), nacc);
            end else begin
                for (int l = 0; l < nacc; l++) begin
                    want.op = op; want.half = half;
                    want.a = !half ? a : (l == 0 ? {16'h0, a[15:0]} : {16'h0, a[31:16]});
                    want.b = !half ? b : (l == 0 ? {16'h0, b[15:0]} : {16'h0, b[31:16]});
                    if (req_log[l] !== want) begin
                        bad++; $display("FAIL rnd%0d_req_payload lane=%0d got=%h want=%h", i, l, req_log[l], want);
                        break;
                    end
                end
            end
        end
        g_dly = 0; d_dly = 1;
    endtask

    task automatic test_idle_payload;
        total++; if (idle_nz !== 0) begin bad++; $display("FAIL idle_payload_nonzero cycles=%0d want=0", idle_nz); end
    endtask

    initial begin
        reset = 1'b1;
        vif.start = 1'b0; vif.op = 1'b0; vif.half = 1'b0; vif.srca = '0; vif.srcb = '0;
        test_reset();
        test_fp32_add();
        test_fp16_mul();
        test_slow_fpu();
        test_timeout();
        test_ignored_inputs();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        test_idle_payload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vfp_issue_sequencer.md
# vfp_issue_sequencer

Sequences vector floating-point instructions (VADD, VMUL, VADDH, VMULH) from the single-cycle core through one shared, variable-latency FP add/multiply unit. Single-precision ops issue one element; half-precision ops issue two 16-bit lanes back-to-back and reassemble the packed result. The block stalls the core for the whole sequence and aborts to a qNaN result with an error flag if the FP unit hangs.

## Interface
- TIMEOUT, 16: cycles allowed in ISSUE or WAIT before abort (>=2).
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  core decodes a vector FP instruction this cycle.
- op  in  1  0 = add, 1 = multiply.
- half  in  1  0 = one fp32 element, 1 = two packed fp16 lanes.
- srca, srcb  in  32  operand registers.
- stall  out  1  hold core PC/writeback.
- done  out  1  one-cycle pulse: result valid, core commits.
- result  out  32  packed result, held until next accepted start.
- err  out  1  valid with done: timeout abort.
- fpu_req  out  1  request to FP unit.
- fpu_gnt  in  1  FP unit accepts request.
- fpu_op, fpu_half  out  1 each  op/precision to FP unit.
- fpu_a, fpu_b  out  32  operands; fp16 lanes zero-extended in [15:0].
- fpu_done  in  1  FP unit result valid.
- fpu_y  in  32  FP unit result; fp16 uses [15:0].

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: start=1 latches op, half, srca, srcb; lane=0; -> ISSUE. start ignored in all other states.
- ISSUE: fpu_req=1, payload stable. Lane 0: fp32 -> srca/srcb; fp16 -> {16'h0, src[15:0]}. Lane 1: {16'h0, src[31:16]}. req&gnt at rising edge -> WAIT.
- WAIT: fpu_done=1 captures fpu_y (fp32: whole word; fp16 lane0 -> result[15:0], lane1 -> result[31:16]). If half and lane=0: lane=1, -> ISSUE; else -> DONE.
- fpu_done outside WAIT and fpu_gnt outside ISSUE are ignored.
- DONE: done=1 for one cycle, err as set; -> IDLE.
- Timeout: counter cleared on every state entry; in ISSUE or WAIT, reaching TIMEOUT-1 without the exit event -> DONE with err=1, result = 32'h7FC00000 (fp32) or 32'h7E007E00 (fp16), fpu_req dropped.
- result/err change only on capture/abort; hold through IDLE.
- Reset (any state, mid-operation included): state=IDLE, counter=0, lane=0, result=0, err=0. All outputs 0 in the cycle after reset. A late fpu_done after reset is ignored.

## Timing
- stall = (state==IDLE & start) | state==ISSUE | state==WAIT. Combinational so the core holds in the start cycle. stall=0 in DONE so the core commits with done.
- Ideal FPU (gnt always 1, fpu_done one cycle after accept): start at cycle 0 -> ISSUE 1 -> WAIT 2 -> DONE 3. fp32 done at cycle 3; fp16 done at cycle 5.
- Back-to-back: start is accepted in IDLE the cycle after DONE, giving a 4-cycle minimum issue interval for fp32.
- fpu_op, fpu_half, fpu_a, fpu_b are driven from registers; they are 0 whenever fpu_req=0.
- Timeout abort: done asserts exactly TIMEOUT cycles after entering the stuck state.

## Test plan
- fp32 add, srca=3F800000, srcb=40000000, gnt=1, model returns 40400000 one cycle after accept -> stall high in cycles 0-2, done at cycle 3, result=40400000, err=0, fpu_op=0, fpu_half=0.
- fp16 mul, srca=40003C00, srcb=42004000 -> first request a=00003C00 b=00004000, second request a=00004000 b=00004200. Model returns 4000 then 4600 -> done at cycle 5, result=46004000.
- gnt held low 3 cycles, fpu_done delayed 4 cycles -> request payload stable while waiting, no spurious done, correct result, err=0.
- fpu_done never asserted, TIMEOUT=16, fp16 -> done+err=1 exactly 16 cycles after WAIT entry, result=7E007E00, fpu_req=0.
- start pulsed during WAIT plus stray fpu_done in IDLE -> both ignored; only one done; result unchanged.
- reset asserted in WAIT of an fp16 op, then fpu_done arrives -> next cycle all outputs 0, state IDLE; a fresh fp32 op completes normally in 3 cycles.
